// File: rtl/sram_controller_ws_if.sv
// Request/acknowledge bus between the CPU/memory-mapping side and sram_controller_ws.
// Defining SRAM_BYTE_LANE_EN adds the BE byte-enable request field.
interface sram_controller_ws_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 18
);
  logic                  REQ;
  logic                  WE;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic [DATA_WIDTH-1:0] DATA_WRITE;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]            BE;
`endif
  logic                  READY;
  logic                  ACK;
  logic [DATA_WIDTH-1:0] DATA_READ;

`ifdef SRAM_BYTE_LANE_EN
  modport master (output REQ, WE, ADDRESS, DATA_WRITE, BE, input READY, ACK, DATA_READ);
  modport slave  (input REQ, WE, ADDRESS, DATA_WRITE, BE, output READY, ACK, DATA_READ);
`else
  modport master (output REQ, WE, ADDRESS, DATA_WRITE, input READY, ACK, DATA_READ);
  modport slave  (input REQ, WE, ADDRESS, DATA_WRITE, output READY, ACK, DATA_READ);
`endif
endinterface

// File: rtl/sram_controller_ws.sv
// Wait-state async SRAM controller: sequences CSX/OEX/WEX with programmable pulse widths.
// SRAM_BYTE_LANE_EN adds BE/UBX/LBX byte lanes; SYNTHESIS selects ICE40 SB_IO pads for DATA.
module sram_controller_ws #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 1,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  sram_controller_ws_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  inout  wire  [DATA_WIDTH-1:0] DATA,
  output logic                  CSX,
  output logic                  OEX,
`ifdef SRAM_BYTE_LANE_EN
  output logic                  WEX,
  output logic                  UBX,
  output logic                  LBX
`else
  output logic                  WEX
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LANE_W = DATA_WIDTH / 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_TURN     = 3'd5;

  localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WRITE_WAIT);
  localparam logic [CNT_W-1:0] TURN_CNT = CNT_W'(TURNAROUND - 1);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cs_q, cs_d, oe_q, oe_d, we_q, we_d;
  logic                  drive_q, drive_d, ack_q, ack_d;
  logic [DATA_WIDTH-1:0] din;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]            be_q, be_d;
  logic                  ub_q, ub_d, lb_q, lb_d;
`endif

  // Next-state and registered control outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cs_d    = cs_q;
    oe_d    = oe_q;
    we_d    = we_q;
    drive_d = drive_q;
    ack_d   = 1'b0;
`ifdef SRAM_BYTE_LANE_EN
    be_d    = be_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          addr_d  = bus.ADDRESS;
          wdata_d = bus.DATA_WRITE;
          cs_d    = 1'b0;
`ifdef SRAM_BYTE_LANE_EN
          be_d    = bus.BE;
          ub_d    = ~bus.BE[1];
          lb_d    = ~bus.BE[0];
`endif
          if (bus.WE) begin
            state_d = S_WR_SETUP;
            drive_d = 1'b1;
            we_d    = 1'b1;
          end else begin
            state_d = S_RD;
            oe_d    = 1'b0;
            cnt_d   = RD_CNT;
          end
        end
      end
      S_RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef SRAM_BYTE_LANE_EN
          rdata_d[DATA_WIDTH-1:LANE_W] = be_q[1] ? din[DATA_WIDTH-1:LANE_W] : rdata_q[DATA_WIDTH-1:LANE_W];
          rdata_d[LANE_W-1:0]          = be_q[0] ? din[LANE_W-1:0] : rdata_q[LANE_W-1:0];
          ub_d = 1'b1;
          lb_d = 1'b1;
`else
          rdata_d = din;
`endif
          ack_d = 1'b1;
          oe_d  = 1'b1;
          cs_d  = 1'b1;
          if (TURNAROUND != 0) begin
            state_d = S_TURN;
            cnt_d   = TURN_CNT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WR_SETUP: begin
        we_d    = 1'b0;
        cnt_d   = WR_CNT;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          we_d    = 1'b1;
          state_d = S_WR_HOLD;
        end
      end
      S_WR_HOLD: begin
        drive_d = 1'b0;
        cs_d    = 1'b1;
        ack_d   = 1'b1;
`ifdef SRAM_BYTE_LANE_EN
        ub_d    = 1'b1;
        lb_d    = 1'b1;
`endif
        state_d = S_IDLE;
      end
      S_TURN: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
`ifdef SRAM_BYTE_LANE_EN
      be_q    <= 2'b00;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
`ifdef SRAM_BYTE_LANE_EN
      be_q    <= be_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
`endif
    end
  end

  assign bus.READY     = (state_q == S_IDLE);
  assign bus.ACK       = ack_q;
  assign bus.DATA_READ = rdata_q;
  assign SRAM_ADDR     = addr_q;
  assign CSX           = cs_q;
  assign OEX           = oe_q;
  assign WEX           = we_q;
`ifdef SRAM_BYTE_LANE_EN
  assign UBX           = ub_q;
  assign LBX           = lb_q;
`endif

  // Data pads: vendor tristate cells on silicon, plain tristate in simulation
`ifdef SYNTHESIS
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_io
    SB_IO #(
      .PIN_TYPE (6'b101001),
      .PULLUP   (1'b0)
    ) u_io (
      .PACKAGE_PIN   (DATA[i]),
      .OUTPUT_ENABLE (drive_q),
      .D_OUT_0       (wdata_q[i]),
      .D_IN_0        (din[i])
    );
  end
`else
  assign DATA = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign din  = DATA;
`endif

endmodule
